// File: rtl/q_update_ctrl.sv
// Q-learning update sequencer: reads Q(s,a) and Q(s',*), finds max Q(s'), drives the update datapath, writes q_new back.
// Optional completed-update counter on upd_count is enabled by defining QCTRL_PERF_CNT_EN.
module q_update_ctrl #(
   parameter int STATE_W  = 4,
   parameter int ACTION_W = 2,
   parameter int ADDR_W   = STATE_W + ACTION_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [STATE_W-1:0]  req_state,
   input  logic [ACTION_W-1:0] req_action,
   input  logic [31:0]         req_reward,
   input  logic [STATE_W-1:0]  req_next_state,
   input  logic                req_terminal,
   input  logic [31:0]         cfg_alpha,
   input  logic [31:0]         cfg_gamma,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_rd_addr,
   input  logic [31:0]         mem_rd_data,
   output logic                mem_wr_en,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [31:0]         mem_wr_data,
   output logic [31:0]         dp_q_old,
   output logic [31:0]         dp_reward,
   output logic [31:0]         dp_max_q_next,
   output logic [31:0]         dp_alpha,
   output logic [31:0]         dp_gamma,
   input  logic [31:0]         dp_q_new,
   output logic                busy,
   output logic                done,
   output logic [15:0]         upd_count
);

   localparam int N_ACTIONS = 2**ACTION_W;
   localparam int IDX_W     = ACTION_W + 1;

   typedef enum logic [2:0] {IDLE, READ, DRAIN, CALC, WRITE} state_t;

   state_t              state, state_nxt;
   logic [STATE_W-1:0]  cur_s, nxt_s;
   logic [ACTION_W-1:0] cur_a;
   logic                term;
   logic [IDX_W-1:0]    rd_idx, cap_idx;
   logic                cap_vld;
   logic [31:0]         q_new_r;
   logic                read_last;
   logic [ACTION_W-1:0] rd_sel;

   assign read_last = term ? (rd_idx == '0) : (rd_idx == IDX_W'(N_ACTIONS));
   assign rd_sel    = ACTION_W'(rd_idx - IDX_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      req_ready   = 1'b0;
      busy        = 1'b1;
      mem_rd_en   = 1'b0;
      mem_rd_addr = '0;
      mem_wr_en   = 1'b0;
      mem_wr_addr = '0;
      mem_wr_data = '0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nxt = READ;
         end
         READ: begin
            mem_rd_en   = 1'b1;
            mem_rd_addr = (rd_idx == '0) ? {cur_s, cur_a} : {nxt_s, rd_sel};
            if (read_last) state_nxt = DRAIN;
         end
         DRAIN: state_nxt = CALC;
         CALC:  state_nxt = WRITE;
         WRITE: begin
            mem_wr_en   = 1'b1;
            mem_wr_addr = {cur_s, cur_a};
            mem_wr_data = q_new_r;
            done        = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read data returns one cycle after the strobe, so the index travels with a one-cycle delay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_s         <= '0;
         cur_a         <= '0;
         nxt_s         <= '0;
         term          <= 1'b0;
         rd_idx        <= '0;
         cap_idx       <= '0;
         cap_vld       <= 1'b0;
         q_new_r       <= '0;
         dp_q_old      <= '0;
         dp_reward     <= '0;
         dp_max_q_next <= '0;
         dp_alpha      <= '0;
         dp_gamma      <= '0;
      end else begin
         cap_vld <= (state == READ);
         cap_idx <= rd_idx;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cur_s         <= req_state;
                  cur_a         <= req_action;
                  nxt_s         <= req_next_state;
                  term          <= req_terminal;
                  dp_reward     <= req_reward;
                  dp_alpha      <= cfg_alpha;
                  dp_gamma      <= cfg_gamma;
                  dp_max_q_next <= '0;
                  rd_idx        <= '0;
               end
            end
            READ:    rd_idx  <= rd_idx + IDX_W'(1);
            CALC:    q_new_r <= dp_q_new;
            default: ;
         endcase
         // The first Q(s',*) value seeds the max; later ones replace it only when strictly larger.
         if (cap_vld) begin
            if (cap_idx == '0)
               dp_q_old <= mem_rd_data;
            else if ((cap_idx == IDX_W'(1)) || ($signed(mem_rd_data) > $signed(dp_max_q_next)))
               dp_max_q_next <= mem_rd_data;
         end
      end
   end

`ifdef QCTRL_PERF_CNT_EN
   logic [15:0] upd_cnt_r;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    upd_cnt_r <= '0;
      else if (done) upd_cnt_r <= upd_cnt_r + 16'd1;
   end

   assign upd_count = upd_cnt_r;
`else
   assign upd_count = '0;
`endif

endmodule

// File: tb/tb_q_update_ctrl.sv
// Self-checking bench for q_update_ctrl: table RAM, Q16.16 update datapath and a transaction-level scoreboard.
module tb_q_update_ctrl;

   localparam int STATE_W  = 4;
   localparam int ACTION_W = 2;
   localparam int ADDR_W   = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_state = '0;
   logic [1:0]  req_action = '0;
   logic [31:0] req_reward = '0;
   logic [3:0]  req_next_state = '0;
   logic        req_terminal = 1'b0;
   logic [31:0] cfg_alpha = '0;
   logic [31:0] cfg_gamma = '0;
   logic        mem_rd_en;
   logic [5:0]  mem_rd_addr;
   logic [31:0] mem_rd_data;
   logic        mem_wr_en;
   logic [5:0]  mem_wr_addr;
   logic [31:0] mem_wr_data;
   logic [31:0] dp_q_old, dp_reward, dp_max_q_next, dp_alpha, dp_gamma, dp_q_new;
   logic        busy, done;
   logic [15:0] upd_count;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   q_update_ctrl #(.STATE_W(STATE_W), .ACTION_W(ACTION_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_state(req_state), .req_action(req_action), .req_reward(req_reward),
      .req_next_state(req_next_state), .req_terminal(req_terminal),
      .cfg_alpha(cfg_alpha), .cfg_gamma(cfg_gamma),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .dp_q_old(dp_q_old), .dp_reward(dp_reward), .dp_max_q_next(dp_max_q_next),
      .dp_alpha(dp_alpha), .dp_gamma(dp_gamma), .dp_q_new(dp_q_new),
      .busy(busy), .done(done), .upd_count(upd_count)
   );

   function automatic logic [31:0] fxMul(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      p = 64'($signed(a)) * 64'($signed(b));
      return p[47:16];
   endfunction

   // Q_new = Q_old + alpha * (r + gamma * maxQ' - Q_old), all Q16.16
   function automatic logic [31:0] fxUpdate(input logic [31:0] q, input logic [31:0] r,
                                            input logic [31:0] m, input logic [31:0] al,
                                            input logic [31:0] ga);
      return q + fxMul(al, r + fxMul(ga, m) - q);
   endfunction

   assign dp_q_new = fxUpdate(dp_q_old, dp_reward, dp_max_q_next, dp_alpha, dp_gamma);

   logic [31:0] mem [0:63];
   logic        ldEn = 1'b0;
   logic [5:0]  ldAddr = '0;
   logic [31:0] ldData = '0;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
      else if (ldEn) mem[ldAddr] <= ldData;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   typedef struct { int cyc; logic [5:0] addr; } rdExp_t;
   typedef struct { int cyc; logic [5:0] addr; logic [31:0] data; logic [31:0] maxq; } wrExp_t;

   rdExp_t      rdq[$];
   wrExp_t      wrq[$];
   logic [5:0]  rdLog[$];
   logic [15:0] expCount = '0;
   int          lastAccCyc = 0;
   int          lastWrCyc = 0;
   logic [5:0]  lastWrAddr = '0;
   logic [31:0] lastWrData = '0;
   logic [31:0] lastMaxQ = '0;
   logic        expRd, expWr, expBusy;
   logic [31:0] mQOld, mMax;
   rdExp_t      rdE;
   wrExp_t      wrE;

   // Transaction scoreboard: on each accept, predict the read sequence and write from the table contents.
   always @(negedge clk) begin
      if (!rst_n) begin
         rdq.delete();
         wrq.delete();
         expCount = '0;
      end else begin
         expBusy = (wrq.size() != 0);
         expRd   = (rdq.size() != 0) && (rdq[0].cyc == cyc);
         expWr   = (wrq.size() != 0) && (wrq[0].cyc == cyc);
         checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
         checkOutput("req_ready", {31'd0, req_ready}, {31'd0, !expBusy});
         checkOutput("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, expRd});
         checkOutput("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, expWr});
         checkOutput("done", {31'd0, done}, {31'd0, expWr});
         checkOutput("upd_count", {16'd0, upd_count}, {16'd0, expCount});
         if (mem_rd_en) rdLog.push_back(mem_rd_addr);
         if (expRd) begin
            checkOutput("rd_addr", {26'd0, mem_rd_addr}, {26'd0, rdq[0].addr});
            void'(rdq.pop_front());
         end
         if (expWr) begin
            checkOutput("wr_addr", {26'd0, mem_wr_addr}, {26'd0, wrq[0].addr});
            checkOutput("wr_data", mem_wr_data, wrq[0].data);
            checkOutput("dp_max_q_next", dp_max_q_next, wrq[0].maxq);
            lastWrCyc  = cyc;
            lastWrAddr = mem_wr_addr;
            lastWrData = mem_wr_data;
            lastMaxQ   = dp_max_q_next;
            void'(wrq.pop_front());
`ifdef QCTRL_PERF_CNT_EN
            expCount = expCount + 16'd1;
`endif
         end
         if (req_valid && req_ready) begin
            lastAccCyc = cyc;
            mQOld = mem[{req_state, req_action}];
            mMax  = '0;
            if (!req_terminal) begin
               mMax = mem[{req_next_state, 2'd0}];
               for (int i = 1; i < 4; i++)
                  if ($signed(mem[{req_next_state, 2'(i)}]) > $signed(mMax)) mMax = mem[{req_next_state, 2'(i)}];
            end
            rdE.cyc = cyc + 1;
            rdE.addr = {req_state, req_action};
            rdq.push_back(rdE);
            if (!req_terminal) begin
               for (int i = 0; i < 4; i++) begin
                  rdE.cyc = cyc + 2 + i;
                  rdE.addr = {req_next_state, 2'(i)};
                  rdq.push_back(rdE);
               end
            end
            wrE.cyc  = cyc + (req_terminal ? 4 : 8);
            wrE.addr = {req_state, req_action};
            wrE.data = fxUpdate(mQOld, req_reward, mMax, cfg_alpha, cfg_gamma);
            wrE.maxq = mMax;
            wrq.push_back(wrE);
         end
      end
   end

   task automatic loadWord(input logic [5:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      ldEn = 1'b1; ldAddr = a; ldData = d;
      @(posedge clk); #1;
      ldEn = 1'b0;
   endtask

   task automatic applyReset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Drive one request; returns one cycle after it is accepted, with inputs scrambled unless valid is held.
   task automatic applyStimulus(input logic [3:0] s, input logic [1:0] a, input logic [31:0] r,
                                input logic [3:0] ns, input logic term, input logic [31:0] al,
                                input logic [31:0] ga, input bit hold, input bit checkGap);
      int n;
      @(posedge clk); #1;
      req_state = s; req_action = a; req_reward = r; req_next_state = ns;
      req_terminal = term; cfg_alpha = al; cfg_gamma = ga; req_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (req_ready) break;
         n++;
         if (n > 40) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            break;
         end
      end
      if (checkGap) checkOutput("b2b_gap", 32'(cyc - lastWrCyc), 32'd1);
      @(posedge clk); #1;
      if (!hold) begin
         req_valid = 1'b0;
         req_state = 4'($urandom); req_action = 2'($urandom); req_reward = $urandom;
         req_next_state = 4'($urandom); req_terminal = 1'($urandom);
         cfg_alpha = $urandom; cfg_gamma = $urandom;
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while (wrq.size() != 0 || !req_ready) begin
         @(negedge clk);
         n++;
         if (n > 40) begin
            checkOutput("idle_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   function automatic logic [31:0] randQ();
      return 32'($signed($urandom_range(0, 16)) - 8) <<< 15;
   endfunction

   logic [5:0]  basicAddrs [5] = '{6'h12, 6'h14, 6'h15, 6'h16, 6'h17};
   logic [3:0]  rs, rns;
   logic [1:0]  ra;
   logic [31:0] keepQ;

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
      checkOutput("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      checkOutput("rst_upd_count", {16'd0, upd_count}, 32'd0);
      rst_n = 1'b1;

      // Basic update
      loadWord(6'h12, 32'h0002_0000);
      loadWord(6'h14, 32'h0000_4000);
      loadWord(6'h15, 32'h0001_0000);
      loadWord(6'h16, 32'h0000_8000);
      loadWord(6'h17, 32'h0000_0000);
      rdLog.delete();
      applyStimulus(4'd4, 2'd2, 32'd0, 4'd5, 1'b0, 32'h0000_8000, 32'h0000_E666, 1'b0, 1'b0);
      waitIdle();
      checkOutput("basic_nreads", 32'(rdLog.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < rdLog.size()) checkOutput("basic_rd_order", {26'd0, rdLog[i]}, {26'd0, basicAddrs[i]});
      checkOutput("basic_max", lastMaxQ, 32'h0001_0000);
      checkOutput("basic_wr_addr", {26'd0, lastWrAddr}, 32'h12);
      checkOutput("basic_wr_data", lastWrData, 32'h0001_7333);
      checkOutput("basic_latency", 32'(lastWrCyc - lastAccCyc), 32'd8);

      // Terminal update
      loadWord(6'h12, 32'h0002_0000);
      rdLog.delete();
      applyStimulus(4'd4, 2'd2, 32'h0001_0000, 4'd5, 1'b1, 32'h0000_8000, 32'h0000_E666, 1'b0, 1'b0);
      waitIdle();
      checkOutput("term_nreads", 32'(rdLog.size()), 32'd1);
      if (rdLog.size() > 0) checkOutput("term_rd_addr", {26'd0, rdLog[0]}, 32'h12);
      checkOutput("term_max", lastMaxQ, 32'd0);
      checkOutput("term_wr_data", lastWrData, 32'h0001_8000);
      checkOutput("term_latency", 32'(lastWrCyc - lastAccCyc), 32'd4);

      // Signed max
      loadWord(6'h12, 32'h0002_0000);
      loadWord(6'h14, 32'hFFFF_0000);
      loadWord(6'h15, 32'hFFFE_0000);
      loadWord(6'h16, 32'hFFFF_8000);
      loadWord(6'h17, 32'hFFFF_0000);
      applyStimulus(4'd4, 2'd2, 32'd0, 4'd5, 1'b0, 32'h0000_8000, 32'h0000_E666, 1'b0, 1'b0);
      waitIdle();
      checkOutput("signed_max", lastMaxQ, 32'hFFFF_8000);

      // Back-to-back with valid held, from a fresh counter
      applyReset();
      for (int i = 0; i < 4; i++) loadWord({4'd7, 2'(i)}, randQ());
      for (int i = 0; i < 4; i++) loadWord({4'd9, 2'(i)}, randQ());
      loadWord({4'd1, 2'd1}, randQ());
      loadWord({4'd2, 2'd3}, randQ());
      applyStimulus(4'd1, 2'd1, randQ(), 4'd7, 1'b0, 32'h0000_4000, 32'h0000_C000, 1'b1, 1'b0);
      applyStimulus(4'd2, 2'd3, randQ(), 4'd9, 1'b0, 32'h0000_2000, 32'h0000_8000, 1'b0, 1'b1);
      waitIdle();
`ifdef QCTRL_PERF_CNT_EN
      checkOutput("b2b_upd_count", {16'd0, upd_count}, 32'd2);
`else
      checkOutput("b2b_upd_count", {16'd0, upd_count}, 32'd0);
`endif

      // Reset during the third READ cycle abandons the update
      keepQ = 32'h0003_0000;
      loadWord({4'd6, 2'd0}, keepQ);
      for (int i = 0; i < 4; i++) loadWord({4'd8, 2'(i)}, randQ());
      applyStimulus(4'd6, 2'd0, 32'h0001_0000, 4'd8, 1'b0, 32'h0000_8000, 32'h0000_8000, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
      checkOutput("midrst_wr_en", {31'd0, mem_wr_en}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      checkOutput("midrst_nowrite", mem[{4'd6, 2'd0}], keepQ);
      checkOutput("midrst_upd_count", {16'd0, upd_count}, 32'd0);

      // Randomized updates, including s' == s and terminal transitions
      for (int t = 0; t < 30; t++) begin
         rs  = 4'($urandom);
         ra  = 2'($urandom);
         rns = ($urandom_range(0, 3) == 0) ? rs : 4'($urandom);
         for (int i = 0; i < 4; i++) loadWord({rns, 2'(i)}, randQ());
         loadWord({rs, ra}, randQ());
         applyStimulus(rs, ra, randQ(), rns, ($urandom_range(0, 3) == 0),
                       32'($urandom_range(0, 32'h10000)), 32'($urandom_range(0, 32'h10000)),
                       1'b0, 1'b0);
         waitIdle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/q_update_ctrl.md
Name: q_update_ctrl

Overview:
- Sequencer for one Q-learning update on the Frozen Lake Q-table. It accepts a transition (s, a, r, s', terminal) over a valid/ready handshake.
- It reads Q(s,a) and Q(s',0..N_ACTIONS-1) from a synchronous-read table RAM and computes max Q(s') internally (signed compare).
- It drives the team's combinational Q16.16 update datapath with registered operands, then writes q_new back to the table.
- One update is in flight at a time. The block sits between the episode/agent logic and the Q-table RAM.

Parameters:
- STATE_W, 4, state index width (16 states)
- ACTION_W, 2, action index width; N_ACTIONS = 2**ACTION_W
- ADDR_W, STATE_W+ACTION_W, table address width; addr = {state, action}

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  transition request valid
- req_ready  out  1  high only in IDLE
- req_state  in  STATE_W  s
- req_action  in  ACTION_W  a
- req_reward  in  32  r, Q16.16
- req_next_state  in  STATE_W  s'
- req_terminal  in  1  s' terminal: max Q(s') forced to 0
- cfg_alpha  in  32  learning rate, Q16.16; sampled at accept
- cfg_gamma  in  32  discount, Q16.16; sampled at accept
- mem_rd_en  out  1  table read strobe
- mem_rd_addr  out  ADDR_W  read address
- mem_rd_data  in  32  read data, valid exactly 1 cycle after mem_rd_en
- mem_wr_en  out  1  table write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  32  write data
- dp_q_old, dp_reward, dp_max_q_next, dp_alpha, dp_gamma  out  32 each  registered datapath operands
- dp_q_new  in  32  datapath result (combinational from dp_* operands)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, coincident with mem_wr_en
- upd_count  out  16  completed-update counter (optional feature)

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0 except req_ready = 1.
  - An update interrupted by reset is abandoned; no write occurs.
- States: IDLE, READ, DRAIN, CALC, WRITE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all req_* and cfg_* fields, clear the max register and read index, go to READ.
- READ:
  - One mem_rd_en per cycle.
  - Index 0 reads addr {s,a} (q_old).
  - Indices 1..N_ACTIONS read {s', idx-1}, unless terminal.
  - Terminal: READ lasts 1 cycle (q_old read only).
  - Non-terminal: READ lasts N_ACTIONS+1 cycles, then go to DRAIN.
- Data capture, each cycle after a read:
  - Index 0 data → q_old register.
  - Index 1 data loads the max register unconditionally.
  - Later data replace max only if signed(data) > signed(max). Ties keep the earlier value.
- DRAIN: captures the last read datum; 1 cycle; go to CALC.
- CALC:
  - dp_* operands hold latched values (dp_max_q_next = 0 if terminal).
  - Register dp_q_new at cycle end; go to WRITE.
- WRITE:
  - mem_wr_en = 1, mem_wr_addr = {s,a}, mem_wr_data = captured q_new, done = 1 for exactly 1 cycle.
  - Next state IDLE.
- Latency, accept edge T to write cycle:
  - Non-terminal (N_ACTIONS=4): write at T+8, req_ready again at T+9.
  - Terminal: write at T+4.
- Handshake rules:
  - req_* inputs are ignored while busy; a held req_valid is accepted on the first IDLE cycle.
  - mem_rd_en and mem_wr_en are never high in the same cycle.
  - cfg_* changes mid-update have no effect.
- s' == s is legal: the reads see pre-update values, because the write is last.
- dp_* outputs hold their last values in IDLE; they change only at accept and at read-data capture.

Optional Feature:
- Macro: QCTRL_PERF_CNT_EN.
- Defined: upd_count increments by 1 on each done pulse and wraps 0xFFFF → 0x0000; cleared by reset.
- Undefined: upd_count tied to 0 and no counter flops are generated.

Test Plan:
- Reset idle check: rst_n low, then high → req_ready = 1; busy, done, mem_rd_en, mem_wr_en = 0; upd_count = 0.
- Basic update: alpha 0x00008000, gamma 0x0000E666; table Q[4,2] = 0x00020000; Q[5,0..3] = 0x00004000, 0x00010000, 0x00008000, 0x00000000; request s=4, a=2, r=0, s'=5, non-terminal, bench uses the team's datapath:
  - read addresses in order 0x12, 0x14, 0x15, 0x16, 0x17;
  - dp_max_q_next = 0x00010000;
  - write addr 0x12, data 0x00017333 at T+8.
- Terminal: same table, terminal = 1, r = 0x00010000:
  - a single read at 0x12;
  - dp_max_q_next = 0;
  - write 0x00018000 at T+4.
- Signed max: Q[5,*] = 0xFFFF0000, 0xFFFE0000, 0xFFFF8000, 0xFFFF0000 → dp_max_q_next = 0xFFFF8000.
- Back-to-back and held valid: req_valid held high across two requests:
  - second accept occurs exactly 1 cycle after the first done;
  - req_* changes during busy are ignored;
  - with QCTRL_PERF_CNT_EN, upd_count = 2.
- Reset mid-operation: assert rst_n during READ cycle 3 → no mem_wr_en, no done, state IDLE, upd_count = 0.
